// File: rtl/varredura_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states and idle line patterns.
package varredura_pkg;

  typedef enum logic [1:0] {
    VARRE       = 2'd0,
    DEBOUNCE    = 2'd1,
    PRESSIONADA = 2'd2,
    SOLTURA     = 2'd3
  } estado_t;

  localparam logic [3:0] COL_RESET  = 4'b1110;
  localparam logic [3:0] LINHA_IDLE = 4'b1111;

  // Lowest-numbered active-low row wins when several rows are closed.
  function automatic logic [1:0] menor_linha(input logic [3:0] l);
    if (!l[0])      return 2'd0;
    else if (!l[1]) return 2'd1;
    else if (!l[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/varredura_teclado_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs; resets to a configurable idle value.
module sincronizador #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/varredura_teclado.sv
// 4x4 keypad scanner: column scan, press/release debounce, one pulse per accepted press.
module varredura_teclado
  import varredura_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] linha_in,
  output logic [3:0] coluna_out,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_pressionada
);

  localparam logic [7:0]  DWELL_LAST = 8'(SCAN_CYCLES - 1);
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0] w_linha_s;

  estado_t    r_estado;
  logic [1:0] r_col;
  logic [3:0] r_coluna;
  logic [7:0] r_dwell;
  logic [15:0] r_deb;
  logic [3:0] r_cap;
  logic [1:0] r_lin;
  logic [3:0] r_tecla;
  logic       r_valida;
  logic       r_press;

  sincronizador #(.W(4), .RST_VAL(LINHA_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (linha_in),
    .o_q   (w_linha_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= VARRE;
      r_col    <= 2'd0;
      r_coluna <= COL_RESET;
      r_dwell  <= 8'd0;
      r_deb    <= 16'd0;
      r_cap    <= LINHA_IDLE;
      r_lin    <= 2'd0;
      r_tecla  <= 4'h0;
      r_valida <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_valida <= 1'b0;
      case (r_estado)
        VARRE: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= 8'd0;
            if (w_linha_s != LINHA_IDLE) begin
              // Column is held; the captured pattern must stay stable to be accepted.
              r_cap    <= w_linha_s;
              r_lin    <= menor_linha(w_linha_s);
              r_deb    <= 16'd0;
              r_estado <= DEBOUNCE;
            end else begin
              r_col    <= r_col + 2'd1;
              r_coluna <= {r_coluna[2:0], r_coluna[3]};
            end
          end else begin
            r_dwell <= r_dwell + 8'd1;
          end
        end
        DEBOUNCE: begin
          if (w_linha_s != r_cap) begin
            r_estado <= VARRE;
            r_dwell  <= 8'd0;
            r_deb    <= 16'd0;
          end else if (r_deb == DEB_LAST) begin
            r_tecla  <= {r_lin, r_col};
            r_valida <= 1'b1;
            r_press  <= 1'b1;
            r_deb    <= 16'd0;
            r_estado <= PRESSIONADA;
          end else begin
            r_deb <= r_deb + 16'd1;
          end
        end
        PRESSIONADA: begin
          if (w_linha_s == LINHA_IDLE) begin
            r_deb    <= 16'd0;
            r_estado <= SOLTURA;
          end
        end
        SOLTURA: begin
          if (w_linha_s != LINHA_IDLE) begin
            r_deb    <= 16'd0;
            r_estado <= PRESSIONADA;
          end else if (r_deb == DEB_LAST) begin
            r_press  <= 1'b0;
            r_deb    <= 16'd0;
            r_dwell  <= 8'd0;
            r_col    <= r_col + 2'd1;
            r_coluna <= {r_coluna[2:0], r_coluna[3]};
            r_estado <= VARRE;
          end else begin
            r_deb <= r_deb + 16'd1;
          end
        end
        default: r_estado <= VARRE;
      endcase
    end
  end

  assign coluna_out        = r_coluna;
  assign tecla             = r_tecla;
  assign tecla_valida      = r_valida;
  assign tecla_pressionada = r_press;

endmodule

// File: tb/tb_varredura_teclado.sv
// Scoreboard bench for varredura_teclado: keypad matrix model, directed timing cases and random presses.
module tb_varredura_teclado;
  import varredura_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] linha_in;
  logic [3:0] coluna_out;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_pressionada;

  logic [15:0] keys;  // bit r*4+c = key at row r, column c is closed
  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic prev_valida = 1'b0;
  int last_code = 0;

  varredura_teclado #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .linha_in          (linha_in),
    .coluna_out        (coluna_out),
    .tecla             (tecla),
    .tecla_valida      (tecla_valida),
    .tecla_pressionada (tecla_pressionada)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads 0 when a closed key sits on the driven (low) column.
  always_comb begin
    linha_in = LINHA_IDLE;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !coluna_out[c]) linha_in[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout got 0 expected 1 at %0t", name, $time);
  endtask

  // Monitor: every accepted press is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("col_onehot", {31'd0, $onehot(~coluna_out)}, 32'd1);
      if (tecla_valida === 1'b1) begin
        if (prev_valida) chk("pulse_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {28'd0, tecla}, 32'hFFFF);
        end else begin
          chk("pulse_tecla", {28'd0, tecla}, exp_q.pop_front());
          chk("pulse_press", {31'd0, tecla_pressionada}, 32'd1);
        end
      end
      prev_valida <= tecla_valida;
    end else begin
      prev_valida <= 1'b0;
    end
  end

  task automatic wait_entry(input logic [3:0] tgt);
    logic [3:0] p;
    bit ok;
    ok = 0;
    p = coluna_out;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (coluna_out == tgt && p != tgt) begin ok = 1; break; end
      p = coluna_out;
    end
    if (!ok) timeout("wait_entry");
  endtask

  task automatic wait_press(input logic lvl);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tecla_pressionada === lvl) begin ok = 1; break; end
    end
    if (!ok) timeout("wait_press");
  endtask

  task automatic bounce(input int k);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      keys[k] = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      keys[k] = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] ec;
    int k;
    keys  = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col",   {28'd0, coluna_out}, {28'd0, COL_RESET});
    chk("rst_tecla", {28'd0, tecla}, 32'h0);
    chk("rst_valid", {31'd0, tecla_valida}, 32'd0);
    chk("rst_press", {31'd0, tecla_pressionada}, 32'd0);
    rst_n = 1'b1;

    // Idle scan: column index advances every 4 cycles.
    chk("scan_k0", {28'd0, coluna_out}, {28'd0, COL_RESET});
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_col", {28'd0, coluna_out}, {28'd0, ec});
      chk("scan_novalid", {31'd0, tecla_valida}, 32'd0);
    end

    // Row 2 / column 1: pulse 8 cycles after debounce entry.
    wait_entry(4'b1101);
    keys[9] = 1'b1;
    exp_q.push_back(9);
    repeat (11) @(negedge clk);
    chk("k9_pre", {31'd0, tecla_valida}, 32'd0);
    @(negedge clk);
    chk("k9_pulse", {31'd0, tecla_valida}, 32'd1);
    chk("k9_tecla", {28'd0, tecla}, 32'h9);
    @(negedge clk);
    chk("k9_post", {31'd0, tecla_valida}, 32'd0);
    chk("k9_press", {31'd0, tecla_pressionada}, 32'd1);
    repeat (186) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      keys[9] = 1'b0; repeat (2) @(negedge clk);
      keys[9] = 1'b1; repeat (2) @(negedge clk);
    end
    keys[9] = 1'b0;
    repeat (10) @(negedge clk);
    chk("rel_held", {31'd0, tecla_pressionada}, 32'd1);
    @(negedge clk);
    chk("rel_fall", {31'd0, tecla_pressionada}, 32'd0);
    chk("rel_nextcol", {28'd0, coluna_out}, 32'hB);
    chk("rel_keep", {28'd0, tecla}, 32'h9);

    // Short row-0 closure on column 0: aborted debounce, same column resumes dwell.
    wait_entry(4'b1110);
    keys[0] = 1'b1;
    repeat (5) @(negedge clk);
    keys[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_samecol", {28'd0, coluna_out}, 32'hE);
    @(negedge clk);
    chk("glitch_advance", {28'd0, coluna_out}, 32'hD);
    chk("glitch_press", {31'd0, tecla_pressionada}, 32'd0);

    // Rows 1 and 3 on column 3: lowest row wins.
    repeat ($urandom_range(0, 15)) @(negedge clk);
    keys[7] = 1'b1; keys[15] = 1'b1;
    exp_q.push_back(7);
    repeat (60) @(negedge clk);
    keys = 16'h0;
    repeat (30) @(negedge clk);

    // Random presses with bounces, interleaved with short glitches.
    for (int it = 0; it < 14; it++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        keys[k] = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        keys[k] = 1'b0;
        repeat ($urandom_range(5, 15)) @(negedge clk);
      end else begin
        bounce(k);
        keys[k] = 1'b1;
        exp_q.push_back(k);
        last_code = k;
        repeat ($urandom_range(40, 80)) @(negedge clk);
        keys[k] = 1'b0;
        bounce(k);
        repeat ($urandom_range(25, 40)) @(negedge clk);
      end
    end
    repeat (40) @(negedge clk);
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_keep", {28'd0, tecla}, last_code);

    // Reset while a key is held, then re-report after release of reset.
    keys[14] = 1'b1;
    exp_q.push_back(14);
    wait_press(1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_col",   {28'd0, coluna_out}, {28'd0, COL_RESET});
    chk("mrst_tecla", {28'd0, tecla}, 32'h0);
    chk("mrst_valid", {31'd0, tecla_valida}, 32'd0);
    chk("mrst_press", {31'd0, tecla_pressionada}, 32'd0);
    repeat (3) @(negedge clk);
    exp_q.push_back(14);
    rst_n = 1'b1;
    wait_press(1'b1);
    chk("mrst_retecla", {28'd0, tecla}, 32'hE);
    keys = 16'h0;
    wait_press(1'b0);
    repeat (5) @(negedge clk);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
